// File: rtl/alu_mesh_pkg.sv
// Shared types and constants for the mesh-node ALU tile and its arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_mesh_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int MODE_W_DEF = 4;

  // ALU opcodes understood by alu_tile; anything above MODE_MAX is illegal
  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_MUL = 4'd2;
  localparam logic [3:0] MODE_DIV = 4'd3;
  localparam logic [3:0] MODE_MOD = 4'd4;
  localparam logic [3:0] MODE_AND = 4'd5;
  localparam logic [3:0] MODE_OR  = 4'd6;
  localparam logic [3:0] MODE_XOR = 4'd7;
  localparam logic [3:0] MODE_GT  = 4'd8;
  localparam logic [3:0] MODE_MAX = 4'd8;

  // Arbiter control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_tile.sv
// Combinational 64-bit ALU tile; illegal modes and divide-by-zero return 0.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the result follows the operands continuously.
module alu_tile
  import alu_mesh_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MODE_W = MODE_W_DEF
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [MODE_W-1:0] i_mode,
  output logic [DATA_W-1:0] o_result
);

  logic w_b_zero;
  assign w_b_zero = (i_b == '0);

  // Opcode decode; all arithmetic wraps modulo 2^DATA_W
  always_comb begin
    o_result = '0;
    case (i_mode)
      MODE_W'(MODE_ADD): o_result = i_a + i_b;
      MODE_W'(MODE_SUB): o_result = i_a - i_b;
      MODE_W'(MODE_MUL): o_result = i_a * i_b;
      MODE_W'(MODE_DIV): o_result = w_b_zero ? '0 : i_a / i_b;
      MODE_W'(MODE_MOD): o_result = w_b_zero ? '0 : i_a % i_b;
      MODE_W'(MODE_AND): o_result = i_a & i_b;
      MODE_W'(MODE_OR):  o_result = i_a | i_b;
      MODE_W'(MODE_XOR): o_result = i_a ^ i_b;
      MODE_W'(MODE_GT):  o_result = {{(DATA_W-1){1'b0}}, (i_a > i_b)};
      default:           o_result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NUM_REQ.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; gnt is all-zero when no request is asserted.
module rr_arbiter
  import alu_mesh_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx
);

  logic w_found;
  int   w_idx;

  // Scan ptr, ptr+1, ... and keep the first hit
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_gnt[w_idx]   = 1'b1;
        o_gnt_idx      = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/alu_tile_arbiter.sv
// Shares one ALU tile among NUM_REQ mesh ports with round-robin grant and registered operands/result.
// Latency: 2 cycles from request accept to resp_valid; at best one op per 3 cycles.
// Backpressure: result held in RESP until the winner's resp_ready; no request accepted outside IDLE.
module alu_tile_arbiter
  import alu_mesh_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MODE_W  = MODE_W_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  input  logic [NUM_REQ*MODE_W-1:0] i_req_mode,
  output logic [NUM_REQ-1:0]        o_resp_valid,
  input  logic [NUM_REQ-1:0]        i_resp_ready,
  output logic [DATA_W-1:0]         o_resp_result,
  output logic                      o_resp_err,
  output logic [DATA_W-1:0]         o_alu_a,
  output logic [DATA_W-1:0]         o_alu_b,
  output logic [MODE_W-1:0]         o_alu_mode,
  input  logic [DATA_W-1:0]         i_alu_result,
  output logic                      o_busy,
  output logic [IDX_W-1:0]          o_grant_id
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant_id;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [MODE_W-1:0]  r_alu_mode;
  logic [DATA_W-1:0]  r_resp_result;
  logic               r_resp_err;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_any_req;
  logic               w_accept;
  logic               w_resp_done;
  logic               w_op_err;
  logic [DATA_W-1:0]  w_sel_a;
  logic [DATA_W-1:0]  w_sel_b;
  logic [MODE_W-1:0]  w_sel_mode;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req     (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_any_req   = |i_req_valid;
  assign w_accept    = (r_state == ST_IDLE) && w_any_req;
  assign w_resp_done = (r_state == ST_RESP) && i_resp_ready[r_grant_id];

  assign w_sel_a    = i_req_a[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_sel_b    = i_req_b[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_sel_mode = i_req_mode[int'(w_gnt_idx)*MODE_W +: MODE_W];

  // Error flag is judged on the operands the tile is actually computing with
  assign w_op_err = (r_alu_mode > MODE_W'(MODE_MAX)) ||
                    (((r_alu_mode == MODE_W'(MODE_DIV)) || (r_alu_mode == MODE_W'(MODE_MOD)))
                     && (r_alu_b == '0));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the combinational handshake strobes; both suppressed while reset is held
  always_comb begin
    w_state_nxt  = r_state;
    o_req_ready  = '0;
    o_resp_valid = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          o_req_ready = i_rst ? '0 : w_gnt;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        o_resp_valid[r_grant_id] = !i_rst;
        if (i_resp_ready[r_grant_id]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture on accept, result capture after EXEC, pointer advance on response handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_mode    <= '0;
      r_resp_result <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a    <= w_sel_a;
        r_alu_b    <= w_sel_b;
        r_alu_mode <= w_sel_mode;
        r_grant_id <= w_gnt_idx;
      end
      if (r_state == ST_EXEC) begin
        r_resp_result <= i_alu_result;
        r_resp_err    <= w_op_err;
      end
      if (w_resp_done) begin
        // Port just served drops to lowest priority next round
        r_rr_ptr <= (r_grant_id == IDX_W'(NUM_REQ-1)) ? '0 : r_grant_id + 1'b1;
      end
    end
  end

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_mode    = r_alu_mode;
  assign o_resp_result = r_resp_result;
  assign o_resp_err    = r_resp_err;
  assign o_grant_id    = r_grant_id;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_tile_arbiter.sv
// Bench for alu_tile_arbiter with a real alu_tile behind it.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_tile_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [N*64-1:0] req_a, req_b;
  logic [N*4-1:0]  req_mode;
  logic [63:0]   resp_result, alu_a, alu_b, alu_result;
  logic          resp_err, busy;
  logic [3:0]    alu_mode;
  logic [1:0]    grant_id;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_tile_arbiter #(.NUM_REQ(N), .DATA_W(64), .MODE_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_mode(req_mode),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_result(resp_result), .o_resp_err(resp_err),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_mode(alu_mode),
    .i_alu_result(alu_result), .o_busy(busy), .o_grant_id(grant_id)
  );

  alu_tile #(.DATA_W(64), .MODE_W(4)) u_tile (
    .i_a(alu_a), .i_b(alu_b), .i_mode(alu_mode), .o_result(alu_result)
  );

  typedef struct {
    int          port;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  mode;
    logic [63:0] res;
    logic        err;
  } vec_t;

  vec_t tbl[12];

  // Reference ALU straight from the opcode definitions
  function automatic logic [63:0] ref_res(logic [63:0] a, logic [63:0] b, logic [3:0] m);
    case (m)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * b;
      4'd3: return (b == 0) ? 64'd0 : a / b;
      4'd4: return (b == 0) ? 64'd0 : a % b;
      4'd5: return a & b;
      4'd6: return a | b;
      4'd7: return a ^ b;
      4'd8: return (a > b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_err(logic [63:0] b, logic [3:0] m);
    return (m > 4'd8) || (((m == 4'd3) || (m == 4'd4)) && (b == 64'd0));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  task automatic set_req(input int p, input logic [63:0] a, input logic [63:0] b, input logic [3:0] m);
    req_valid[p] = 1'b1;
    req_a[p*64 +: 64] = a;
    req_b[p*64 +: 64] = b;
    req_mode[p*4 +: 4] = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] oh(input int p);
    logic [3:0] one;
    one = 4'b0001;
    return 64'(one << p);
  endfunction

  // Single op with resp_ready held high; entered just after a clock edge with the DUT idle
  task automatic do_op(input int p, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] m, input logic [63:0] er, input logic ee);
    clear_reqs();
    set_req(p, a, b, m);
    @(negedge clk);
    chk("accept_ready", 64'(req_ready), oh(p));
    cyc();
    clear_reqs();
    @(negedge clk);
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_no_resp", 64'(resp_valid), 64'd0);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_mode", 64'(alu_mode), 64'(m));
    cyc();
    @(negedge clk);
    chk("resp_valid", 64'(resp_valid), oh(p));
    chk("resp_result", resp_result, er);
    chk("resp_err", 64'(resp_err), 64'(ee));
    chk("grant_id", 64'(grant_id), 64'(p));
    cyc();
  endtask

  // Random-phase model state
  bit [N-1:0]  pend;
  logic [63:0] pa[N], pb[N];
  logic [3:0]  pm[N];
  int          wcnt[N];
  bit          in_flight;
  int          fport, age, mptr, best, bestd;
  logic [63:0] fres;
  logic        ferr;
  logic [3:0]  exp_rdy, exp_rv;

  initial begin
    tbl[0]  = '{2, 64'd7,  64'd5, 4'd0,  64'd12, 1'b0};
    tbl[1]  = '{1, 64'd3,  64'd4, 4'd2,  64'd12, 1'b0};
    tbl[2]  = '{0, 64'd9,  64'd0, 4'd3,  64'd0,  1'b1};
    tbl[3]  = '{3, 64'd5,  64'd6, 4'd12, 64'd0,  1'b1};
    tbl[4]  = '{1, 64'd17, 64'd5, 4'd4,  64'd2,  1'b0};
    tbl[5]  = '{2, 64'd3,  64'd5, 4'd1,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    tbl[6]  = '{0, 64'd5,  64'd3, 4'd8,  64'd1,  1'b0};
    tbl[7]  = '{3, 64'hF0, 64'hFF, 4'd7, 64'h0F, 1'b0};
    tbl[8]  = '{2, 64'h8000_0000_0000_0000, 64'd2, 4'd2, 64'd0, 1'b0};
    tbl[9]  = '{1, 64'd5,  64'd0, 4'd4,  64'd0,  1'b1};
    tbl[10] = '{0, 64'd1,  64'd1, 4'd9,  64'd0,  1'b1};
    tbl[11] = '{3, 64'hC,  64'hA, 4'd5,  64'h8,  1'b0};

    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_mode = '0;
    resp_ready = '1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_mode", 64'(alu_mode), 64'd0);
    chk("rst_result", resp_result, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    cyc();
    rst = 1'b0;

    // Table of single ops
    for (int i = 0; i < 12; i++)
      do_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].res, tbl[i].err);

    // Round robin from a fresh pointer: all ports valid, SUB 100 - i
    do_reset();
    for (int p = 0; p < N; p++) set_req(p, 64'd100, 64'(p), 4'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_ready", 64'(req_ready), oh(k % N));
      cyc();
      @(negedge clk);
      chk("rr_exec_no_ready", 64'(req_ready), 64'd0);
      cyc();
      @(negedge clk);
      chk("rr_resp_valid", 64'(resp_valid), oh(k % N));
      chk("rr_result", resp_result, 64'(100 - (k % N)));
      chk("rr_resp_no_ready", 64'(req_ready), 64'd0);
      cyc();
    end
    clear_reqs();

    // Backpressure: pointer is now 1, port 1 wins over port 0 and is held off
    set_req(1, 64'd3, 64'd4, 4'd2);
    set_req(0, 64'd1, 64'd1, 4'd0);
    resp_ready = 4'b1101;
    @(negedge clk);
    chk("bp_ready", 64'(req_ready), 64'h2);
    cyc();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp_exec_ready", 64'(req_ready), 64'd0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(resp_valid), 64'h2);
      chk("bp_hold_result", resp_result, 64'd12);
      chk("bp_hold_no_ready", 64'(req_ready), 64'd0);
      cyc();
    end
    resp_ready = 4'b1111;
    @(negedge clk);
    chk("bp_release_valid", 64'(resp_valid), 64'h2);
    cyc();
    @(negedge clk);
    chk("bp_port0_ready", 64'(req_ready), 64'h1);
    cyc();
    clear_reqs();
    cyc();
    @(negedge clk);
    chk("bp_port0_valid", 64'(resp_valid), 64'h1);
    chk("bp_port0_result", resp_result, 64'd2);
    cyc();

    // Wrap: a port-2 completion leaves the pointer at 3
    do_op(2, 64'd1, 64'd1, 4'd0, 64'd2, 1'b0);
    set_req(0, 64'd10, 64'd1, 4'd0);
    set_req(3, 64'd20, 64'd1, 4'd0);
    @(negedge clk);
    chk("wrap_ready3", 64'(req_ready), 64'h8);
    cyc();
    cyc();
    @(negedge clk);
    chk("wrap_valid3", 64'(resp_valid), 64'h8);
    chk("wrap_result3", resp_result, 64'd21);
    chk("wrap_grant3", 64'(grant_id), 64'd3);
    cyc();
    @(negedge clk);
    chk("wrap_ready0", 64'(req_ready), 64'h1);
    cyc();
    clear_reqs();
    cyc();
    @(negedge clk);
    chk("wrap_result0", resp_result, 64'd11);
    cyc();

    // Reset during EXEC: op dropped, pointer back to 0 so port 1 beats port 3
    do_op(1, 64'd2, 64'd2, 4'd0, 64'd4, 1'b0);
    set_req(3, 64'd5, 64'd5, 4'd0);
    @(negedge clk);
    chk("mid_ready", 64'(req_ready), 64'h8);
    cyc();
    clear_reqs();
    rst = 1'b1;
    set_req(1, 64'd6, 64'd7, 4'd0);
    set_req(3, 64'd8, 64'd8, 4'd0);
    @(negedge clk);
    chk("mid_rst_no_ready", 64'(req_ready), 64'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_resp", 64'(resp_valid), 64'd0);
    chk("mid_not_busy", 64'(busy), 64'd0);
    chk("mid_ready_port1", 64'(req_ready), 64'h2);
    cyc();
    clear_reqs();
    @(negedge clk);
    chk("mid_exec_no_resp", 64'(resp_valid), 64'd0);
    cyc();
    @(negedge clk);
    chk("mid_resp_valid", 64'(resp_valid), 64'h2);
    chk("mid_result", resp_result, 64'd13);
    chk("mid_grant", 64'(grant_id), 64'd1);
    cyc();

    // Randomized traffic against the behavioural model
    do_reset();
    pend = '0;
    in_flight = 1'b0;
    mptr = 0; fport = 0; age = 0; fres = '0; ferr = 1'b0;
    for (int i = 0; i < N; i++) wcnt[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            pa[i] = {$urandom, $urandom};
            case ($urandom_range(0, 3))
              0: pb[i] = 64'd0;
              1: pb[i] = {$urandom, $urandom};
              default: pb[i] = 64'($urandom_range(1, 20));
            endcase
            pm[i] = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
          wcnt[i] = 0;
        end
        req_valid[i] = pend[i];
        req_a[i*64 +: 64] = pa[i];
        req_b[i*64 +: 64] = pb[i];
        req_mode[i*4 +: 4] = pm[i];
      end
      resp_ready = 4'($urandom_range(0, 15));
      @(negedge clk);
      exp_rdy = '0;
      exp_rv = '0;
      best = -1;
      bestd = N;
      if (!in_flight) begin
        for (int i = 0; i < N; i++) begin
          if (pend[i] && (((i - mptr + N) % N) < bestd)) begin
            bestd = (i - mptr + N) % N;
            best = i;
          end
        end
        if (best >= 0) exp_rdy = 4'(oh(best));
      end else if (age >= 2) begin
        exp_rv = 4'(oh(fport));
      end
      chk("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rnd_resp_valid", 64'(resp_valid), 64'(exp_rv));
      chk("rnd_busy", 64'(busy), 64'(in_flight));
      if (exp_rv != 0) begin
        chk("rnd_result", resp_result, fres);
        chk("rnd_err", 64'(resp_err), 64'(ferr));
        chk("rnd_grant", 64'(grant_id), 64'(fport));
      end
      if (!in_flight) begin
        if (best >= 0) begin
          for (int i = 0; i < N; i++)
            if (pend[i] && i != best) wcnt[i]++;
          chk("rnd_fairness", 64'(wcnt[best] < N), 64'd1);
          wcnt[best] = 0;
          in_flight = 1'b1;
          fport = best;
          fres = ref_res(pa[best], pb[best], pm[best]);
          ferr = ref_err(pb[best], pm[best]);
          age = 1;
          pend[best] = 1'b0;
        end
      end else if (age >= 2) begin
        if (resp_ready[fport]) begin
          in_flight = 1'b0;
          mptr = (fport + 1) % N;
        end
      end else begin
        age++;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
